// File: rtl/riscv_core_mdu.sv
// riscv_core_mdu: iterative RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// N = 64 iterations (32 for W-ops), with a divide-by-zero/overflow fast path.
module riscv_core_mdu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_mdu_clk,
  input  logic            i_mdu_rstn,
  input  logic            i_mdu_start,
  input  logic            i_mdu_kill,
  input  logic [2:0]      i_mdu_funct3,
  input  logic            i_mdu_word,
  input  logic [XLEN-1:0] i_mdu_a,
  input  logic [XLEN-1:0] i_mdu_b,
  output logic [XLEN-1:0] o_mdu_result,
  output logic            o_mdu_busy,
  output logic            o_mdu_done,
  output logic            o_mdu_divby0,
  output logic            o_mdu_of
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_word;
  logic            r_neg;
  logic            r_rneg;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mc;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_result;
  logic            r_done;
  logic            r_divby0;
  logic            r_of;

  logic [2:0]      w_f3;
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_sx, w_b_sx, w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic [XLEN-1:0] w_min, w_fast_res;
  logic            w_is_div, w_b_zero, w_ovf;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_sub;
  logic [PW-1:0]   w_acc_nxt, w_mc_nxt, w_prod;
  logic [XLEN-1:0] w_x_nxt, w_quo, w_rem, w_sel, w_final;

  // Operand decode: op normalisation, signedness, magnitudes and fast-path detection
  always_comb begin
    w_f3    = (i_mdu_word && !i_mdu_funct3[2]) ? 3'b000 : i_mdu_funct3;
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (w_f3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
      end
      3'b010:  w_a_sgn = 1'b1;
      default: ;
    endcase
    w_a_sx   = i_mdu_word ? {{HW{i_mdu_a[HW-1]}}, i_mdu_a[HW-1:0]} : i_mdu_a;
    w_b_sx   = i_mdu_word ? {{HW{i_mdu_b[HW-1]}}, i_mdu_b[HW-1:0]} : i_mdu_b;
    w_a_ext  = (i_mdu_word && !w_a_sgn) ? {{HW{1'b0}}, i_mdu_a[HW-1:0]} : w_a_sx;
    w_b_ext  = (i_mdu_word && !w_b_sgn) ? {{HW{1'b0}}, i_mdu_b[HW-1:0]} : w_b_sx;
    w_a_neg  = w_a_sgn && w_a_ext[XLEN-1];
    w_b_neg  = w_b_sgn && w_b_ext[XLEN-1];
    w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    w_is_div = w_f3[2];
    w_b_zero = (w_b_ext == '0);
    w_min    = i_mdu_word ? {{(HW + 1){1'b1}}, {(HW - 1){1'b0}}} : {1'b1, {(XLEN - 1){1'b0}}};
    w_ovf    = w_is_div && !w_f3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
    if (w_b_zero) w_fast_res = w_f3[1] ? w_a_sx : '1;
    else          w_fast_res = w_f3[1] ? '0 : w_a_sx;
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_rem_sh = {r_acc[XLEN-1:0], r_x[XLEN-1]};
    w_sub    = (w_rem_sh >= {1'b0, r_mc[XLEN-1:0]});
    w_diff   = w_rem_sh - {1'b0, r_mc[XLEN-1:0]};
    if (r_f3[2]) begin
      w_acc_nxt = {{(XLEN - 1){1'b0}}, (w_sub ? w_diff : w_rem_sh)};
      w_mc_nxt  = r_mc;
      w_x_nxt   = {r_x[XLEN-2:0], w_sub};
    end else begin
      w_acc_nxt = r_x[0] ? (r_acc + r_mc) : r_acc;
      w_mc_nxt  = r_mc << 1;
      w_x_nxt   = r_x >> 1;
    end
  end

  // Final sign correction, result selection and W sign-extension
  always_comb begin
    w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_quo  = r_neg ? -w_x_nxt : w_x_nxt;
    w_rem  = r_rneg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    if (r_f3[2])               w_sel = r_f3[1] ? w_rem : w_quo;
    else if (r_f3 == 3'b000)   w_sel = w_prod[XLEN-1:0];
    else                       w_sel = w_prod[PW-1:XLEN];
    w_final = r_word ? {{HW{w_sel[HW-1]}}, w_sel[HW-1:0]} : w_sel;
  end

  // Control FSM with datapath registers and registered status outputs
  always_ff @(posedge i_mdu_clk or negedge i_mdu_rstn) begin
    if (!i_mdu_rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_x      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_divby0 <= 1'b0;
      r_of     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_divby0 <= 1'b0;
      r_of     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mdu_start && !i_mdu_kill) begin
            r_f3   <= w_f3;
            r_word <= i_mdu_word;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_acc  <= '0;
            r_mc   <= {{XLEN{1'b0}}, (w_is_div ? w_b_mag : w_a_mag)};
            if (w_is_div)
              r_x <= i_mdu_word ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
            else
              r_x <= w_b_mag;
            r_cnt <= i_mdu_word ? CW'(HW - 1) : CW'(XLEN - 1);
            if (w_is_div && (w_b_zero || w_ovf)) begin
              r_result <= w_fast_res;
              r_divby0 <= w_b_zero;
              r_of     <= w_ovf && !w_b_zero;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_mdu_kill) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_mc  <= w_mc_nxt;
            r_x   <= w_x_nxt;
            if (r_cnt == '0) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mdu_busy   = i_mdu_rstn && ((r_state != S_IDLE) || (i_mdu_start && !i_mdu_kill));
  assign o_mdu_result = r_result;
  assign o_mdu_done   = r_done;
  assign o_mdu_divby0 = r_divby0;
  assign o_mdu_of     = r_of;

endmodule

// File: tb/tb_riscv_core_mdu.sv
// Directed testbench for riscv_core_mdu: hand-computed vectors, latency,
// busy window, fast paths, kill, asynchronous reset and back-to-back ops.
module tb_riscv_core_mdu;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] opa;
  logic [63:0] opb;
  logic [63:0] result;
  logic        busy;
  logic        done;
  logic        divby0;
  logic        ovf;

  int checks;
  int failures;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  riscv_core_mdu #(.XLEN(64)) dut (
    .i_mdu_clk    (clk),
    .i_mdu_rstn   (rstn),
    .i_mdu_start  (start),
    .i_mdu_kill   (kill),
    .i_mdu_funct3 (funct3),
    .i_mdu_word   (word),
    .i_mdu_a      (opa),
    .i_mdu_b      (opb),
    .o_mdu_result (result),
    .o_mdu_busy   (busy),
    .o_mdu_done   (done),
    .o_mdu_divby0 (divby0),
    .o_mdu_of     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op like the stalled pipeline would (start held until the edge ending DONE)
  // and report what was observed; called #1 after a rising edge.
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output logic dz,
                       output logic of, output int lat, output logic busy_ok);
    start = 1'b1; funct3 = f3; word = w; opa = a; opb = b;
    lat = -1; busy_ok = 1'b1; res = '0; dz = 1'b0; of = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        res = result; dz = divby0; of = ovf; lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; kill = 1'b0; funct3 = 3'b000; word = 1'b0;
    opa = 64'd7; opb = 64'd3;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (divby0 !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", divby0, ovf); end
    start = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffffffffffeb", res); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL mul_latency got=%0d exp=65", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL mul_busy_window got=%b exp=1", bok); end
    checks++; if (dz !== 1'b0 || of !== 1'b0) begin failures++; $display("FAIL mul_flags got=%b%b exp=00", dz, of); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mul_after_done got busy=%b done=%b exp=0 0", busy, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_mulh();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b011, 1'b0, ONES, ONES, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_result got=%h exp=fffffffffffffffe", res); end
    do_op(3'b010, 1'b0, ONES, 64'd2, res, dz, of, lat, bok);
    checks++; if (res !== ONES) begin failures++; $display("FAIL mulhsu_result got=%h exp=ffffffffffffffff", res); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL mulhsu_latency got=%0d exp=65", lat); end
  endtask

  task automatic test_divby0();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b101, 1'b0, 64'd100, 64'd0, res, dz, of, lat, bok);
    checks++; if (res !== ONES) begin failures++; $display("FAIL divu0_result got=%h exp=ffffffffffffffff", res); end
    checks++; if (dz !== 1'b1 || of !== 1'b0) begin failures++; $display("FAIL divu0_flags got=%b%b exp=10", dz, of); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL divu0_latency got=%0d exp=1", lat); end
    do_op(3'b110, 1'b0, 64'd100, 64'd0, res, dz, of, lat, bok);
    checks++; if (res !== 64'd100) begin failures++; $display("FAIL rem0_result got=%h exp=64", res); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL rem0_divby0 got=%b exp=1", dz); end
  endtask

  task automatic test_overflow();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divw_of_result got=%h exp=ffffffff80000000", res); end
    checks++; if (of !== 1'b1 || dz !== 1'b0) begin failures++; $display("FAIL divw_of_flags got of=%b dz=%b exp=1 0", of, dz); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL divw_of_latency got=%0d exp=1", lat); end
    do_op(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, res, dz, of, lat, bok);
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL remw_of_result got=%h exp=0", res); end
    checks++; if (of !== 1'b1) begin failures++; $display("FAIL remw_of_flag got=%b exp=1", of); end
  endtask

  task automatic test_div();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_result got=%h exp=fffffffffffffffd", res); end
    do_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, dz, of, lat, bok);
    checks++; if (res !== ONES) begin failures++; $display("FAIL rem_result got=%h exp=ffffffffffffffff", res); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL rem_latency got=%0d exp=65", lat); end
    do_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, res, dz, of, lat, bok);
    checks++; if (res !== ONES) begin failures++; $display("FAIL divuw_result got=%h exp=ffffffffffffffff", res); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divuw_latency got=%0d exp=33", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL divuw_busy_window got=%b exp=1", bok); end
  endtask

  task automatic test_kill();
    logic [63:0] res; logic dz, of, bok; int lat; int ndone;
    do_op(3'b101, 1'b0, 64'd100, 64'd0, res, dz, of, lat, bok);
    start = 1'b1; funct3 = 3'b000; word = 1'b0; opa = 64'd5; opb = 64'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    kill = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", busy); end
    checks++; if (result !== ONES) begin failures++; $display("FAIL kill_result_held got=%h exp=ffffffffffffffff", result); end
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", ndone); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [63:0] res; logic dz, of, bok; int lat; int ndone;
    do_op(3'b110, 1'b0, 64'd100, 64'd0, res, dz, of, lat, bok);
    start = 1'b1; funct3 = 3'b000; word = 1'b0; opa = 64'd5; opb = 64'd5;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL areset_result got=%h exp=0", result); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL areset_busy_done got=%b%b exp=00", busy, done); end
    start = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0 || busy !== 1'b0) begin failures++; $display("FAIL areset_idle got dones=%0d busy=%b exp=0 0", ndone, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; logic dz, of, bok; int lat;
    do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL b2b_first_result got=%h exp=fffffffffffffffd", res); end
    do_op(3'b011, 1'b0, ONES, ONES, res, dz, of, lat, bok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL b2b_second_result got=%h exp=fffffffffffffffe", res); end
    checks++; if (lat !== 65 || bok !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got lat=%0d busy_ok=%b exp=65 1", lat, bok); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_divby0();
    test_overflow();
    test_div();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_core_mdu.md
# riscv_core_mdu

Iterative RV64M multiply/divide unit in the EX stage, beside the ALU. It accepts one M-extension operation at a time from the EX pipeline register and runs a radix-2 shift-add multiply or restoring divide over 64 (or 32 for W-ops) cycles. It reports busy/done/divide-by-zero/overflow to the hazard unit, which stalls IF through WB while `busy && !done` and raises an exception on either flag. Results go to the EX result mux.

## Interface
- `XLEN`, 64, datapath width; only 64 is supported.

- `i_mdu_clk` in 1: core clock.
- `i_mdu_rstn` in 1: reset, asynchronous, active-low.
- `i_mdu_start` in 1: M-op present in EX. Held by the pipeline while stalled.
- `i_mdu_kill` in 1: abort the current operation. Has priority over start.
- `i_mdu_funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_mdu_word` in 1: W-variant (OP-32). Operands use bits [31:0]; result is sign-extended from bit 31.
- `i_mdu_a` in XLEN: rs1 operand (already forwarded).
- `i_mdu_b` in XLEN: rs2 operand (already forwarded).
- `o_mdu_result` out XLEN: result, valid while `o_mdu_done` is high.
- `o_mdu_busy` out 1: operation accepted or in progress.
- `o_mdu_done` out 1: one-cycle completion pulse.
- `o_mdu_divby0` out 1: DIV/DIVU/REM/REMU(/W) with zero divisor. Valid with done.
- `o_mdu_of` out 1: signed DIV/REM(/W) of MIN by −1. Valid with done.

## Operation
- **FSM states.** IDLE, CALC, DONE.
- **IDLE.**
  - If `start && !kill`, latch the operands, op and word into registers.
  - Divide by zero, or signed MIN/−1: go to DONE directly (fast path).
  - Otherwise: load the counter with N−1 and go to CALC. N = 32 if word, else 64.
- **CALC.** One iteration per cycle.
  - Leave CALC when the counter reaches 0.
  - The final signed correction and the W sign-extension are applied on that last edge. The result register is written on entry to DONE.
- **DONE.** One cycle, then IDLE. `start` is ignored in DONE.
- **Multiply.**
  - Operate on magnitudes. Signedness by op: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Negate the 2·N-bit product if the operand signs differ (signed operands only).
  - MUL and MULW return the low N bits. MULH* return the high 64 bits.
  - `word` with funct3 001–011 is executed as MULW.
- **Divide.**
  - Restoring divide on magnitudes.
  - Quotient sign = sign(a) XOR sign(b), for signed ops only.
  - Remainder sign = sign(a).
- **Divide-by-zero fast path.**
  - Quotient = all ones (N bits).
  - Remainder = a (N bits).
  - `o_mdu_divby0` = 1.
- **Overflow fast path** (a = −2^(N−1), b = −1, signed).
  - Quotient = a.
  - Remainder = 0.
  - `o_mdu_of` = 1.
- **Sign-extension.** W results are always sign-extended from bit 31, including fast-path results.
- **`o_mdu_busy`.** Combinational: `(state != IDLE) || (start && !kill && state == IDLE)`. This makes the hazard unit stall in the same cycle the op is first presented.
- **`o_mdu_done`, `o_mdu_divby0`, `o_mdu_of`.** Registered; high only in DONE.
- **`o_mdu_result`.** Holds its last value until the next entry to DONE.
- **Kill.** In CALC, `kill` returns the FSM to IDLE on the next edge. No done pulse; the result is unchanged. Kill in DONE has no effect (done still pulses).

## Timing
- **Reset values.** State IDLE; `result`, `done`, `divby0`, `of` all 0. `busy` = 0 while in reset.
- **Asynchronous reset mid-operation.** Immediate return to IDLE; no done.
- **Latency** (start sampled at edge E0, i.e. cycle 0):
  - Normal op: CALC occupies cycles 1..N; `done` = 1 in cycle N+1. That is 65 cycles for 64-bit ops, 33 for W-ops.
  - Fast path: `done` in cycle 1.
- **Stall window.** `busy` is high from cycle 0 through the done cycle. `busy && !done` is low only in the done cycle, so the pipeline advances on the edge that ends DONE.
- **Back-to-back ops.** A new op may be accepted in the IDLE cycle that immediately follows DONE. Throughput is one op per N+2 cycles.
- **Counter.** 6 bits, counts down. No wrap: the FSM exits at 0.

## Test plan
- **MUL:** a=7, b=−3 → result 0xFFFF_FFFF_FFFF_FFEB; `done` in cycle 65; `busy` high cycles 0–65; `divby0` = `of` = 0.
- **MULHU:** a = b = 0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. **MULHSU:** a=−1, b=2 → result 0xFFFF_FFFF_FFFF_FFFF.
- **DIVU:** a=100, b=0 → result all ones, `divby0` = 1, `done` in cycle 1. **REM** with the same operands → result 100.
- **DIVW overflow:** a=0x8000_0000, b=0xFFFF_FFFF, word=1 → result 0xFFFF_FFFF_8000_0000, `of` = 1, `done` in cycle 1. **REMW** with the same operands → result 0.
- **DIV:** a=−7, b=2 → result −3. **REM:** a=−7, b=2 → result −1; `done` in cycle 65. **DIVUW:** a=0xFFFF_FFFF, b=1 → result 0xFFFF_FFFF_FFFF_FFFF in cycle 33.
- **Abort and reset.**
  - `kill` in CALC cycle 10 → IDLE next cycle, no `done`, `result` unchanged.
  - `i_mdu_rstn` low in cycle 20 → all outputs 0 immediately.
  - Then start two consecutive ops → second accepted in the cycle after the first `done`.
